// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB_Manager command port among NUM_REQ requesters.
// Latency: req_i sampled at edge E gives transfer in cycle E+1; done is high the cycle after ready is sampled.
// Backpressure: one transaction at a time; losing requesters hold req_i until granted, and none are dropped.
//
// Ports:
//   PCLK, PRESET                      clock (rising edge) and asynchronous active-low reset
//   req_i / req_write_i               per-requester request level and direction (1 = write)
//   req_addr_i / req_wdata_i          packed payloads; requester k uses slice [k*W +: W]
//   gnt_o / req_done_o                one-hot owner, and a one-cycle completion pulse to that owner
//   req_err_o / req_rdata_o           timeout flag and read data, valid only with req_done_o
//   transfer/write/addr/wdata         latched command to APB_Manager; transfer is a one-cycle start pulse
//   rdata/ready                       APB_Manager response
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        req_done_o,
    output logic                      req_err_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic                      transfer,
    output logic                      write,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W-1:0]         rdata,
    input  logic                      ready
);

    localparam int IW = $clog2(NUM_REQ);
    // A disabled watchdog (TIMEOUT = 0) still needs a legal 1-bit timer.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

    state_t              state_q, state_nxt;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_nxt;
    logic [IW-1:0]       idx_q, idx_nxt;
    logic [TW-1:0]       timer_q, timer_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
    logic                err_nxt, transfer_nxt, write_nxt;
    logic [DATA_W-1:0]   rdata_nxt, wdata_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    logic                win_vld;
    logic [IW-1:0]       win_idx;

    // Winner search starts at rr_ptr and wraps, so the last owner has lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        rr_ptr_nxt   = rr_ptr_q;
        idx_nxt      = idx_q;
        timer_nxt    = timer_q;
        gnt_nxt      = gnt_o;
        done_nxt     = '0;
        err_nxt      = req_err_o;
        rdata_nxt    = req_rdata_o;
        transfer_nxt = 1'b0;
        write_nxt    = write;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_nxt      = win_idx;
                    write_nxt    = req_write_i[win_idx];
                    addr_nxt     = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_nxt    = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                    gnt_nxt      = NUM_REQ'(1) << win_idx;
                    transfer_nxt = 1'b1;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ready) begin
                    rdata_nxt = write ? '0 : rdata;
                    err_nxt   = 1'b0;
                    done_nxt  = gnt_o;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    done_nxt  = gnt_o;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0) begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            RESP: begin
                // req_i is deliberately not looked at here: the owner drops it on this edge.
                rr_ptr_nxt = IW'((int'(idx_q) + 1) % NUM_REQ);
                gnt_nxt    = '0;
                err_nxt    = 1'b0;
                rdata_nxt  = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset aborts any transaction silently; the owner must re-request.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            gnt_o       <= '0;
            req_done_o  <= '0;
            req_err_o   <= 1'b0;
            req_rdata_o <= '0;
            transfer    <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
        end else begin
            state_q     <= state_nxt;
            rr_ptr_q    <= rr_ptr_nxt;
            idx_q       <= idx_nxt;
            timer_q     <= timer_nxt;
            gnt_o       <= gnt_nxt;
            req_done_o  <= done_nxt;
            req_err_o   <= err_nxt;
            req_rdata_o <= rdata_nxt;
            transfer    <= transfer_nxt;
            write       <= write_nxt;
            addr        <= addr_nxt;
            wdata       <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  req_write_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic [1:0]  gnt_o;
    logic [1:0]  req_done_o;
    logic        req_err_o;
    logic [31:0] req_rdata_o;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_i(req_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .gnt_o(gnt_o), .req_done_o(req_done_o), .req_err_o(req_err_o),
        .req_rdata_o(req_rdata_o), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Runs one transaction from IDLE: ready pulses ready_delay cycles after the
    // transfer cycle (never if negative). Bounded at 60 cycles.
    task automatic run_txn(input int ready_delay, input logic [31:0] rd, input bit drop,
                           output logic [1:0] gnt_seen, output logic [1:0] done_seen,
                           output int n_xfer, output int cyc, output logic err_seen,
                           output logic [31:0] rdata_seen, output logic [31:0] addr_seen);
        int since;
        since = -1;
        gnt_seen = '0; done_seen = '0; n_xfer = 0; cyc = 0;
        err_seen = 1'b0; rdata_seen = '0; addr_seen = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            ready = 1'b0;
            if (transfer) begin
                n_xfer++;
                gnt_seen = gnt_o;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (req_done_o != 2'b00) begin
                done_seen = req_done_o;
                err_seen = req_err_o;
                rdata_seen = req_rdata_o;
                addr_seen = addr;
                cyc = c;
                if (drop) req_i = req_i & ~req_done_o;
                break;
            end
            if (ready_delay > 0 && since == ready_delay) begin
                ready = 1'b1;
                rdata = rd;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b0;
        tick(); tick();
        n_checks++;
        if ({gnt_o, req_done_o, req_err_o, transfer, write} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0", {gnt_o, req_done_o, req_err_o, transfer, write});
        end
        n_checks++;
        if ({addr, wdata, req_rdata_o} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", {addr, wdata, req_rdata_o});
        end
        PRESET = 1'b1;
        tick();
    endtask

    task automatic test_write_t1();
        req_write_i = 2'b01;
        req_addr_i[31:0] = 32'h1000_1004;
        req_wdata_i[31:0] = 32'hDEAD_BEEF;
        req_i = 2'b01;
        tick(); // SETUP
        n_checks++;
        if ({transfer, gnt_o, write} !== 4'b1011) begin
            n_fail++; $display("FAIL t1_setup: got xfer/gnt/write %b required 1011", {transfer, gnt_o, write});
        end
        n_checks++;
        if (addr !== 32'h1000_1004 || wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL t1_cmd: got %h/%h required 10001004/deadbeef", addr, wdata);
        end
        tick(); // WAIT 1
        n_checks++;
        if (transfer !== 1'b0 || req_done_o !== 2'b00) begin
            n_fail++; $display("FAIL t1_wait1: got xfer %b done %b required 0/00", transfer, req_done_o);
        end
        tick(); // WAIT 2
        ready = 1'b1;
        rdata = 32'h5555_AAAA;
        tick(); // RESP
        ready = 1'b0;
        n_checks++;
        if (req_done_o !== 2'b01 || req_err_o !== 1'b0 || req_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL t1_done: got done %b err %b rdata %h required 01/0/0", req_done_o, req_err_o, req_rdata_o);
        end
        req_i = 2'b00;
        tick(); // IDLE
        n_checks++;
        if (req_done_o !== 2'b00 || gnt_o !== 2'b00 || transfer !== 1'b0) begin
            n_fail++; $display("FAIL t1_idle: got done %b gnt %b xfer %b required 00/00/0", req_done_o, gnt_o, transfer);
        end
    endtask

    task automatic test_read_t2();
        req_write_i = 2'b00;
        req_addr_i[63:32] = 32'h1000_2008;
        req_i = 2'b10;
        tick(); // SETUP
        n_checks++;
        if ({transfer, gnt_o, write} !== 4'b1100 || addr !== 32'h1000_2008) begin
            n_fail++; $display("FAIL t2_setup: got %b addr %h required 1100 addr 10002008", {transfer, gnt_o, write}, addr);
        end
        tick(); // WAIT
        ready = 1'b1;
        rdata = 32'h1234_5678;
        tick(); // RESP
        ready = 1'b0;
        rdata = 32'h0;
        n_checks++;
        if (req_done_o !== 2'b10 || req_rdata_o !== 32'h1234_5678 || req_err_o !== 1'b0) begin
            n_fail++; $display("FAIL t2_done: got done %b rdata %h err %b required 10/12345678/0", req_done_o, req_rdata_o, req_err_o);
        end
        req_i = 2'b00;
        tick();
    endtask

    task automatic test_round_robin_t3();
        logic [1:0] g, d, exp_g;
        logic e;
        logic [31:0] r, a;
        int nx, cy;
        PRESET = 1'b0;
        req_i = 2'b11;
        req_write_i = 2'b00;
        tick();
        PRESET = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            run_txn(1, 32'h100 + n, 1'b0, g, d, nx, cy, e, r, a);
            n_checks++;
            if (g !== exp_g || d !== exp_g || nx != 1) begin
                n_fail++; $display("FAIL t3_order%0d: got gnt %b done %b transfers %0d required %b/%b/1", n, g, d, nx, exp_g, exp_g);
            end
            n_checks++;
            if (r !== 32'h100 + n) begin
                n_fail++; $display("FAIL t3_rdata%0d: got %h required %h", n, r, 32'h100 + n);
            end
        end
        req_i = 2'b00;
        tick(); tick();
    endtask

    task automatic test_timeout_t4();
        logic [1:0] g, d;
        logic e;
        logic [31:0] r, a;
        int nx, cy;
        req_write_i = 2'b00;
        req_addr_i[31:0] = 32'h1000_0040;
        rdata = 32'hAAAA_5555;
        req_i = 2'b01;
        run_txn(-1, 32'h0, 1'b1, g, d, nx, cy, e, r, a);
        // transfer in cycle 1, 8 WAIT cycles, done in cycle 10
        n_checks++;
        if (d !== 2'b01 || e !== 1'b1 || r !== 32'h0 || cy != 10) begin
            n_fail++; $display("FAIL t4_timeout: got done %b err %b rdata %h cycle %0d required 01/1/0/10", d, e, r, cy);
        end
        tick(); // IDLE
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++;
        if (req_done_o !== 2'b00 || gnt_o !== 2'b00 || transfer !== 1'b0) begin
            n_fail++; $display("FAIL t4_late_ready: got done %b gnt %b xfer %b required 00/00/0", req_done_o, gnt_o, transfer);
        end
        tick();
        n_checks++;
        if (req_done_o !== 2'b00) begin
            n_fail++; $display("FAIL t4_late_ready2: got done %b required 00", req_done_o);
        end
        rdata = 32'h0;
    endtask

    task automatic test_payload_hold_t5();
        req_write_i = 2'b00;
        req_addr_i[31:0] = 32'h1000_0000;
        req_i = 2'b01;
        tick(); // SETUP
        n_checks++;
        if (addr !== 32'h1000_0000 || gnt_o !== 2'b01) begin
            n_fail++; $display("FAIL t5_grant: got addr %h gnt %b required 10000000/01", addr, gnt_o);
        end
        req_addr_i[31:0] = 32'h1000_3FFC;
        tick(); // WAIT
        n_checks++;
        if (addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL t5_wait: got addr %h required 10000000", addr);
        end
        tick();
        ready = 1'b1;
        rdata = 32'h0BAD_F00D;
        tick(); // RESP
        ready = 1'b0;
        n_checks++;
        if (req_done_o !== 2'b01 || addr !== 32'h1000_0000 || req_rdata_o !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL t5_done: got done %b addr %h rdata %h required 01/10000000/0badf00d", req_done_o, addr, req_rdata_o);
        end
        req_i = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_t6();
        logic [1:0] g, d;
        logic e;
        logic [31:0] r, a;
        int nx, cy;
        req_write_i = 2'b11;
        req_addr_i = {32'h1000_0B00, 32'h1000_0A00};
        req_wdata_i = {32'h2222_2222, 32'h1111_1111};
        req_i = 2'b10;
        tick(); // SETUP
        tick(); // WAIT
        n_checks++;
        if (gnt_o !== 2'b10 || write !== 1'b1) begin
            n_fail++; $display("FAIL t6_pre: got gnt %b write %b required 10/1", gnt_o, write);
        end
        #2;
        PRESET = 1'b0;
        req_i = 2'b11;
        #1;
        n_checks++;
        if ({gnt_o, req_done_o, req_err_o, transfer, write} !== 7'b0 || {addr, wdata, req_rdata_o} !== 96'b0) begin
            n_fail++; $display("FAIL t6_async: got ctrl %b data %h required 0", {gnt_o, req_done_o, req_err_o, transfer, write}, {addr, wdata, req_rdata_o});
        end
        tick();
        n_checks++;
        if (req_done_o !== 2'b00) begin
            n_fail++; $display("FAIL t6_nodone: got done %b required 00", req_done_o);
        end
        PRESET = 1'b1;
        run_txn(1, 32'h0, 1'b1, g, d, nx, cy, e, r, a);
        n_checks++;
        if (g !== 2'b01 || d !== 2'b01 || a !== 32'h1000_0A00) begin
            n_fail++; $display("FAIL t6_first: got gnt %b done %b addr %h required 01/01/10000a00", g, d, a);
        end
        run_txn(1, 32'h0, 1'b1, g, d, nx, cy, e, r, a);
        n_checks++;
        if (g !== 2'b10 || d !== 2'b10 || a !== 32'h1000_0B00) begin
            n_fail++; $display("FAIL t6_second: got gnt %b done %b addr %h required 10/10/10000b00", g, d, a);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_t1();
        test_read_t2();
        test_round_robin_t3();
        test_timeout_t4();
        test_payload_hold_t5();
        test_reset_mid_t6();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
